// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
// Optional duty-cycle measurement is enabled by the FREQ_METER_DUTY_EN macro.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        FM_IDLE    = 2'd0,
        FM_MEASURE = 2'd1,
        FM_DONE    = 2'd2
    } fm_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_if.sv
// Measurement request/result bundle between a controller (master) and freq_meter (slave).
// high_count exists only when FREQ_METER_DUTY_EN is defined.
interface freq_meter_if #(
    parameter int CNT_W = 16
);
    // start is a level sampled only while the meter is idle; done is a one-cycle
    // strobe, and the result fields are valid from that cycle until the next accepted start.
    logic             clk_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;
    logic             overflow;
`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] high_count;

    modport master (output clk_in, start, input busy, done, edge_count, overflow, high_count);
    modport slave  (input clk_in, start, output busy, done, edge_count, overflow, high_count);
`else
    modport master (output clk_in, start, input busy, done, edge_count, overflow);
    modport slave  (input clk_in, start, output busy, done, edge_count, overflow);
`endif

endinterface

// File: rtl/freq_meter_sync_rise_det.sv
// Multi-flop synchroniser followed by a registered previous value for rise detection.
// Reusable by any block that needs edges of an asynchronous or divider-derived clock.
module sync_rise_det
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q_sync = r_sync[SYNC_STAGES-1];
    assign rise   = q_sync & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rises of bus.clk_in over GATE_CYCLES clk cycles.
// Define FREQ_METER_DUTY_EN to also count clk cycles with clk_in high (high_count).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    freq_meter_if.slave   bus,
    output fm_state_t     o_dbg_state
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    fm_state_t         r_state;
    logic [GATE_W-1:0] r_gate;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_edge;
    logic              r_ovf;
    logic              w_rise;
`ifdef FREQ_METER_DUTY_EN
    logic              w_sync;
    logic [CNT_W-1:0]  r_high;
`else
    logic              w_unused_sync;
`endif

    sync_rise_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (bus.clk_in),
`ifdef FREQ_METER_DUTY_EN
        .q_sync (w_sync),
`else
        .q_sync (w_unused_sync),
`endif
        .rise   (w_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FM_IDLE;
            r_gate  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_edge  <= '0;
            r_ovf   <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            r_high  <= '0;
`endif
        end else begin
            case (r_state)
                FM_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= FM_MEASURE;
                        r_busy  <= 1'b1;
                        r_gate  <= '0;
                        r_edge  <= '0;
                        r_ovf   <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
                        r_high  <= '0;
`endif
                    end
                end
                FM_MEASURE: begin
                    r_gate <= r_gate + 1'b1;
                    // Saturating counters; an increment lost at the ceiling marks overflow.
                    if (w_rise) begin
                        if (r_edge == CNT_MAX) r_ovf  <= 1'b1;
                        else                   r_edge <= r_edge + 1'b1;
                    end
`ifdef FREQ_METER_DUTY_EN
                    if (w_sync) begin
                        if (r_high == CNT_MAX) r_ovf  <= 1'b1;
                        else                   r_high <= r_high + 1'b1;
                    end
`endif
                    if (r_gate == GATE_LAST) begin
                        r_state <= FM_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FM_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= FM_IDLE;
                end
                default: begin
                    r_state <= FM_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.edge_count = r_edge;
    assign bus.overflow   = r_ovf;
`ifdef FREQ_METER_DUTY_EN
    assign bus.high_count = r_high;
`endif
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a table of periodic clk_in patterns with hand-computed
// counts, plus reset-mid-window and start-while-busy sequences.
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int G_A = 60;
    localparam int G_B = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(16)) bus_a ();
    freq_meter_if #(.CNT_W(4))  bus_b ();
    fm_state_t dbg_a;
    fm_state_t dbg_b;

    freq_meter #(.GATE_CYCLES(G_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .o_dbg_state(dbg_a));
    freq_meter #(.GATE_CYCLES(G_B), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .o_dbg_state(dbg_b));

    int n_cmp = 0;
    int n_bad = 0;
    int pat_per = 1;
    int pat_hi  = 0;
    int pat_ph  = 0;

    // Table record: sel picks dut_b; the pattern is pat_hi high cycles out of pat_per.
    typedef struct {
        bit sel;
        int per;
        int hi;
        int e_edge;
        int e_high;
        int e_ovf;
        int e_ovf_duty;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pat_ph = (pat_ph + 1) % pat_per;
        bus_a.clk_in = (pat_ph < pat_hi);
        bus_b.clk_in = (pat_ph < pat_hi);
    endtask

    task automatic set_pattern(input int per, input int hi);
        pat_per = per;
        pat_hi  = hi;
        pat_ph  = 0;
        bus_a.clk_in = (hi > 0);
        bus_b.clk_in = (hi > 0);
        for (int i = 0; i < 8; i++) tick();
    endtask

    function automatic int get_busy(input bit sel);
        return sel ? int'(bus_b.busy) : int'(bus_a.busy);
    endfunction
    function automatic int get_done(input bit sel);
        return sel ? int'(bus_b.done) : int'(bus_a.done);
    endfunction
    function automatic int get_edge(input bit sel);
        return sel ? int'(bus_b.edge_count) : int'(bus_a.edge_count);
    endfunction
    function automatic int get_ovf(input bit sel);
        return sel ? int'(bus_b.overflow) : int'(bus_a.overflow);
    endfunction
    function automatic int get_state(input bit sel);
        return sel ? int'(dbg_b) : int'(dbg_a);
    endfunction
`ifdef FREQ_METER_DUTY_EN
    function automatic int get_high(input bit sel);
        return sel ? int'(bus_b.high_count) : int'(bus_a.high_count);
    endfunction
`endif

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.start = v;
        else     bus_a.start = v;
    endtask

    // Steps until done shows up or the budget runs out; busy must stay high until then.
    task automatic wait_done(input bit sel, input int budget,
                             output int n, output bit seen, output bit busy_ok);
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (n < budget && !seen) begin
            if (get_done(sel) == 1) begin
                seen = 1'b1;
            end else begin
                if (get_busy(sel) != 1) busy_ok = 1'b0;
                tick();
                n++;
            end
        end
    endtask

    task automatic measure(input string name, input bit sel, input int e_edge,
                           input int e_high, input int e_ovf);
        int  g;
        int  n;
        bit  seen;
        bit  busy_ok;
        g = sel ? G_B : G_A;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        check({name, ".busy_after_start"}, get_busy(sel), 1);
        wait_done(sel, g + 8, n, seen, busy_ok);
        check({name, ".done_seen"}, int'(seen), 1);
        check({name, ".done_latency"}, n, g);
        check({name, ".busy_in_window"}, int'(busy_ok), 1);
        check({name, ".busy_at_done"}, get_busy(sel), 0);
        check({name, ".edge_count"}, get_edge(sel), e_edge);
        check({name, ".overflow"}, get_ovf(sel), e_ovf);
`ifdef FREQ_METER_DUTY_EN
        check({name, ".high_count"}, get_high(sel), e_high);
`else
        if (e_high < 0) check({name, ".high_arg"}, e_high, 0);
`endif
        tick();
        check({name, ".done_one_cycle"}, get_done(sel), 0);
        check({name, ".edge_hold"}, get_edge(sel), e_edge);
    endtask

    vec_t vecs[13];

    initial begin
        int  n;
        int  n2;
        int  dones;
        bit  seen;
        bit  busy_ok;
        bit  busy_seen;

        vecs[0]  = '{0, 3, 1, 20, 20, 0, 0};
        vecs[1]  = '{0, 3, 2, 20, 40, 0, 0};
        vecs[2]  = '{0, 4, 2, 15, 30, 0, 0};
        vecs[3]  = '{0, 2, 1, 30, 30, 0, 0};
        vecs[4]  = '{0, 5, 2, 12, 24, 0, 0};
        vecs[5]  = '{0, 1, 1, 0,  60, 0, 0};
        vecs[6]  = '{0, 1, 0, 0,  0,  0, 0};
        vecs[7]  = '{1, 2, 1, 15, 15, 1, 1};
        vecs[8]  = '{1, 1, 0, 0,  0,  0, 0};
        vecs[9]  = '{1, 8, 4, 8,  15, 0, 1};
        vecs[10] = '{1, 16, 15, 4, 15, 0, 1};
        vecs[11] = '{1, 4, 1, 15, 15, 1, 1};
        vecs[12] = '{1, 1, 1, 0,  15, 0, 1};

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_a.clk_in = 1'b0;
        bus_b.clk_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset%0d.busy", s), get_busy(s[0]), 0);
            check($sformatf("reset%0d.done", s), get_done(s[0]), 0);
            check($sformatf("reset%0d.edge", s), get_edge(s[0]), 0);
            check($sformatf("reset%0d.ovf", s), get_ovf(s[0]), 0);
            check($sformatf("reset%0d.state", s), get_state(s[0]), int'(FM_IDLE));
`ifdef FREQ_METER_DUTY_EN
            check($sformatf("reset%0d.high", s), get_high(s[0]), 0);
`endif
        end

        for (int v = 0; v < 13; v++) begin
            set_pattern(vecs[v].per, vecs[v].hi);
`ifdef FREQ_METER_DUTY_EN
            measure($sformatf("vec%0d", v), vecs[v].sel, vecs[v].e_edge, vecs[v].e_high,
                    vecs[v].e_ovf_duty);
`else
            measure($sformatf("vec%0d", v), vecs[v].sel, vecs[v].e_edge, vecs[v].e_high,
                    vecs[v].e_ovf);
`endif
        end

        // Reset ten cycles into a window: everything clears and no done follows.
        set_pattern(3, 1);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid.busy", get_busy(0), 0);
        check("rstmid.done", get_done(0), 0);
        check("rstmid.edge", get_edge(0), 0);
        check("rstmid.ovf", get_ovf(0), 0);
        check("rstmid.state", get_state(0), int'(FM_IDLE));
`ifdef FREQ_METER_DUTY_EN
        check("rstmid.high", get_high(0), 0);
`endif
        dones = 0;
        for (int i = 0; i < G_A + 5; i++) begin
            if (get_done(0) == 1) dones++;
            tick();
        end
        check("rstmid.no_done", dones, 0);
        measure("rstmid.fresh", 0, 20, 20, 0);

        // Start pulsed mid-window and in the done cycle must be ignored.
        set_pattern(4, 2);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_done(0, G_A + 8, n, seen, busy_ok);
        check("busystart.done_seen", int'(seen), 1);
        check("busystart.latency", n + 5, G_A);
        check("busystart.busy_in_window", int'(busy_ok), 1);
        check("busystart.busy_at_done", get_busy(0), 0);
        check("busystart.edge", get_edge(0), 15);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        dones = 0;
        busy_seen = 1'b0;
        for (n2 = 0; n2 < G_A + 5; n2++) begin
            if (get_done(0) == 1) dones++;
            if (get_busy(0) == 1) busy_seen = 1'b1;
            tick();
        end
        check("busystart.extra_done", dones, 0);
        check("busystart.no_restart", int'(busy_seen), 0);
        check("busystart.edge_hold", get_edge(0), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
